// File: rtl/divider_pkg.sv
`default_nettype none
// ============================================================================
// Module      : divider_pkg
// Description : Shared state encoding and counter sizing for divider_iterative.
// Revision    : 1.0 - initial release
// ============================================================================
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam int C_DEFAULT_WIDTH = 32;
  localparam int C_DEFAULT_CNT_W = $clog2(C_DEFAULT_WIDTH);

  // Step counter width for a given operand width: it must reach WIDTH-1.
  function automatic int count_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/divider_step.sv
`default_nettype none
// ============================================================================
// Module      : divider_step
// Description : One combinational restoring-division step.
// Revision    : 1.0 - initial release
// ============================================================================
module divider_step
  import divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dividend_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  // The shifted remainder needs WIDTH+1 bits; after a subtract it fits WIDTH.
  logic [WIDTH:0] w_shifted;

  assign w_shifted = {rem_in, dividend_msb};
  assign q_bit     = (w_shifted >= {1'b0, divisor});
  assign rem_out   = q_bit ? (w_shifted[WIDTH-1:0] - divisor) : w_shifted[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/divider_iterative.sv
`default_nettype none
// ============================================================================
// Module      : divider_iterative
// Description : Iterative signed/unsigned restoring divider, one bit per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module divider_iterative
  import divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             valid_out,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int                    C_CNT_BITS = count_width(WIDTH);
  localparam logic [C_CNT_BITS-1:0] C_LAST     = C_CNT_BITS'(WIDTH - 1);

  state_t                r_state;
  state_t                w_next_state;
  logic                  w_busy;
  logic [WIDTH-1:0]      r_rem;
  logic [WIDTH-1:0]      r_dvd;
  logic [WIDTH-1:0]      r_dvs;
  logic [C_CNT_BITS-1:0] r_cnt;
  logic                  r_q_neg;
  logic                  r_r_neg;
  logic                  r_dz;
  logic                  r_valid_out;
  logic [WIDTH-1:0]      r_quotient;
  logic [WIDTH-1:0]      r_remainder;
  logic                  r_div_by_zero;
  logic [WIDTH-1:0]      w_a_mag;
  logic [WIDTH-1:0]      w_b_mag;
  logic [WIDTH-1:0]      w_rem_next;
  logic                  w_q_bit;

  assign w_a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
  assign w_b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

  divider_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_in      (r_rem),
    .dividend_msb(r_dvd[WIDTH-1]),
    .divisor     (r_dvs),
    .rem_out     (w_rem_next),
    .q_bit       (w_q_bit)
  );

  // A new request always wins, discarding whatever is in flight.
  always_comb begin
    w_next_state = r_state;
    w_busy       = 1'b0;
    case (r_state)
      RUN: begin
        w_busy = 1'b1;
        if (r_cnt == C_LAST) w_next_state = FIX;
      end
      FIX: begin
        w_busy       = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
    if (valid_in) w_next_state = RUN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_rem         <= '0;
      r_dvd         <= '0;
      r_dvs         <= '0;
      r_cnt         <= '0;
      r_q_neg       <= 1'b0;
      r_r_neg       <= 1'b0;
      r_dz          <= 1'b0;
      r_valid_out   <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_valid_out <= 1'b0;
      if (valid_in) begin
        r_rem   <= '0;
        r_dvd   <= w_a_mag;
        r_dvs   <= w_b_mag;
        r_cnt   <= '0;
        r_q_neg <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]) & (b != '0);
        r_r_neg <= is_signed & a[WIDTH-1];
        r_dz    <= (b == '0);
      end else if (r_state == RUN) begin
        // Dividend shifts out the top while quotient bits fill from the bottom.
        r_rem <= w_rem_next;
        r_dvd <= {r_dvd[WIDTH-2:0], w_q_bit};
        r_cnt <= r_cnt + 1'b1;
      end else if (r_state == FIX) begin
        r_quotient    <= r_q_neg ? -r_dvd : r_dvd;
        r_remainder   <= r_r_neg ? -r_rem : r_rem;
        r_div_by_zero <= r_dz;
        r_valid_out   <= 1'b1;
      end
    end
  end

  assign busy        = w_busy;
  assign valid_out   = r_valid_out;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;

endmodule
`default_nettype wire

// File: tb/tb_divider_iterative.sv
`default_nettype none
// ============================================================================
// Module      : tb_divider_iterative
// Description : Self-checking bench for divider_iterative against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divider_iterative;

  localparam int C_W = 32;

  logic           clk;
  logic           reset;
  logic           valid_in;
  logic           is_signed;
  logic [C_W-1:0] a;
  logic [C_W-1:0] b;
  logic           busy;
  logic           valid_out;
  logic [C_W-1:0] quotient;
  logic [C_W-1:0] remainder;
  logic           div_by_zero;

  int n_pass  = 0;
  int n_total = 0;

  divider_iterative #(
    .WIDTH(C_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .is_signed  (is_signed),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .valid_out  (valid_out),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Reference: plain integer division in 64-bit arithmetic.
  task automatic model(input logic [C_W-1:0] ma, input logic [C_W-1:0] mb, input logic ms,
                       output logic [C_W-1:0] q, output logic [C_W-1:0] r, output logic dz);
    longint sa;
    longint sb;
    dz = (mb == 0);
    if (mb == 0) begin
      q = '1;
      r = ma;
    end else if (!ms) begin
      q = ma / mb;
      r = ma % mb;
    end else begin
      sa = longint'($signed(ma));
      sb = longint'($signed(mb));
      q  = C_W'(sa / sb);
      r  = C_W'(sa % sb);
    end
  endtask

  // Issues one operation on the current negedge and watches 40 cycles.
  task automatic run_op(input logic [C_W-1:0] ta, input logic [C_W-1:0] tb, input logic ts);
    logic [C_W-1:0] eq;
    logic [C_W-1:0] er;
    logic           edz;
    int             lat;
    int             pulses;
    int             busy_cnt;
    logic [C_W-1:0] got_q;
    logic [C_W-1:0] got_r;
    logic           got_dz;
    model(ta, tb, ts, eq, er, edz);
    lat = -1; pulses = 0; busy_cnt = 0;
    got_q = '0; got_r = '0; got_dz = 1'b0;
    valid_in = 1'b1; a = ta; b = tb; is_signed = ts;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        valid_in = 1'b0;
        a = $urandom; b = $urandom; is_signed = $urandom_range(0, 1);
      end
      if (busy) busy_cnt++;
      if (valid_out) begin
        pulses++;
        if (lat < 0) begin
          lat = k; got_q = quotient; got_r = remainder; got_dz = div_by_zero;
        end
        check("busy_low_at_valid", 64'(busy), 64'd0);
      end
    end
    check("latency", 64'(lat), 64'd34);
    check("pulse_count", 64'(pulses), 64'd1);
    check("busy_cycles", 64'(busy_cnt), 64'd33);
    check("quotient", 64'(got_q), 64'(eq));
    check("remainder", 64'(got_r), 64'(er));
    check("div_by_zero", 64'(got_dz), 64'(edz));
  endtask

  initial begin
    int pulses;
    int lat;
    logic [C_W-1:0] ra;
    logic [C_W-1:0] rb;
    reset = 1'b1; valid_in = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    @(negedge clk); @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(valid_out), 64'd0);
    check("rst_quotient", 64'(quotient), 64'd0);
    check("rst_remainder", 64'(remainder), 64'd0);
    check("rst_dz", 64'(div_by_zero), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(32'd100, 32'd7, 1'b0);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op(32'h0000_1234, 32'd0, 1'b0);
    run_op(32'h0000_1234, 32'd0, 1'b1);
    run_op(32'hFFFF_FF00, 32'd0, 1'b1);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1);
    run_op(32'd5, 32'd9, 1'b0);

    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      case (i % 4)
        0: rb = $urandom;
        1: rb = $urandom_range(1, 255);
        2: rb = -$urandom_range(1, 255);
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      run_op(ra, rb, 1'($urandom_range(0, 1)));
    end

    // Restart mid-run: only the second operation may complete.
    pulses = 0; lat = -1;
    valid_in = 1'b1; a = 32'd100; b = 32'd7; is_signed = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      valid_in = 1'b0;
      if (k == 10) begin
        valid_in = 1'b1; a = 32'd50; b = 32'd5; is_signed = 1'b0;
      end
      if (valid_out) begin
        pulses++;
        if (lat < 0) lat = k;
        check("restart_quotient", 64'(quotient), 64'd10);
        check("restart_remainder", 64'(remainder), 64'd0);
      end
    end
    check("restart_pulses", 64'(pulses), 64'd1);
    check("restart_latency", 64'(lat), 64'd44);

    // Leave a nonzero result visible, then abort a run with reset.
    run_op(32'd100, 32'd7, 1'b0);
    valid_in = 1'b1; a = 32'd100; b = 32'd7; is_signed = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      valid_in = 1'b0;
    end
    reset = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_valid", 64'(valid_out), 64'd0);
    check("abort_quotient", 64'(quotient), 64'd0);
    check("abort_remainder", 64'(remainder), 64'd0);
    check("abort_dz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (valid_out) pulses++;
    end
    check("abort_no_valid", 64'(pulses), 64'd0);
    run_op(32'd9, 32'd4, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
